// File: rtl/data_memory_arbiter_pkg.sv
// Shared definitions for the data memory arbiter: FSM encodings and default base address.
package data_memory_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1001_0000;

endpackage

// File: rtl/data_memory_arbiter_rr_arbiter2.sv
// Two-requester round-robin arbiter, purely combinational.
// Also intended for the instruction-side loader, so it carries no state of its own.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic [1:0] gnt
);

  // On a tie the port that was not served last wins; otherwise pass the lone request.
  always_comb begin
    gnt = 2'b00;
    if (req == 2'b11) begin
      gnt = last_gnt ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/data_memory_arbiter.sv
// Two-port round-robin arbiter and one-cycle access sequencer for the single-port data memory.
//
// state  | meaning
// IDLE   | waiting for a request; latches winner, address, data and error bit
// ACCESS | drives memory strobes for one cycle (suppressed on a rejected address)
// RESP   | pulses ack/err/rdata to the winning port only
module data_memory_arbiter
  import data_memory_arbiter_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    MEMORY_DEPTH = 2048,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR    = DATA_WIDTH'(DEFAULT_BASE_ADDR)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [DATA_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_ack,
  output logic                  m0_err,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [DATA_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_ack,
  output logic                  m1_err,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_write,
  output logic                  mem_read,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  state_t                state, state_next;
  logic                  last_gnt;
  logic                  we_q, port_q, err_q;
  logic [DATA_WIDTH-1:0] addr_q, wdata_q, rdata_q;

  logic [1:0]            req_vec, gnt;
  logic                  sel_port, sel_we;
  logic [DATA_WIDTH-1:0] sel_addr, sel_wdata;

  // Rejects addresses below the window, misaligned words, and word indices past the end.
  function automatic logic addr_err(input logic [DATA_WIDTH-1:0] a);
    logic [DATA_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return (a < BASE_ADDR) | (a[1:0] != 2'b00) |
           ((off >> 2) >= DATA_WIDTH'(MEMORY_DEPTH));
  endfunction

  assign req_vec = {m1_req, m0_req};

  rr_arbiter2 u_rr (
    .req      (req_vec),
    .last_gnt (last_gnt),
    .gnt      (gnt)
  );

  assign sel_port  = gnt[1];
  assign sel_we    = sel_port ? m1_we    : m0_we;
  assign sel_addr  = sel_port ? m1_addr  : m0_addr;
  assign sel_wdata = sel_port ? m1_wdata : m0_wdata;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode and all outputs, which are zero outside their owning state.
  always_comb begin
    state_next = state;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_write  = 1'b0;
    mem_read   = 1'b0;
    m0_ack     = 1'b0;
    m0_err     = 1'b0;
    m0_rdata   = '0;
    m1_ack     = 1'b0;
    m1_err     = 1'b0;
    m1_rdata   = '0;
    case (state)
      IDLE: begin
        if (|req_vec) state_next = ACCESS;
      end
      ACCESS: begin
        state_next = RESP;
        if (!err_q) begin
          mem_addr  = addr_q;
          mem_wdata = wdata_q;
          mem_write = we_q;
          mem_read  = !we_q;
        end
      end
      RESP: begin
        state_next = IDLE;
        if (port_q) begin
          m1_ack   = 1'b1;
          m1_err   = err_q;
          m1_rdata = rdata_q;
        end else begin
          m0_ack   = 1'b1;
          m0_err   = err_q;
          m0_rdata = rdata_q;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Transaction latch, read capture and round-robin pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_gnt <= 1'b1;
      we_q     <= 1'b0;
      port_q   <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_vec) begin
            we_q    <= sel_we;
            port_q  <= sel_port;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            err_q   <= addr_err(sel_addr);
          end
        end
        ACCESS:  rdata_q  <= (!err_q && !we_q) ? mem_rdata : '0;
        RESP:    last_gnt <= port_q;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Scoreboard bench for data_memory_arbiter with a behavioural single-port memory.
module tb_data_memory_arbiter;

  localparam logic [31:0] BASE  = 32'h1001_0000;
  localparam int          DEPTH = 2048;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        m0_req = 1'b0, m0_we = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0;
  logic        m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m1_addr = '0, m1_wdata = '0;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_write, mem_read;

  data_memory_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_ack    (m0_ack),
    .m0_err    (m0_err),
    .m0_rdata  (m0_rdata),
    .m1_req    (m1_req),
    .m1_we     (m1_we),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_ack    (m1_ack),
    .m1_err    (m1_err),
    .m1_rdata  (m1_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_write (mem_write),
    .mem_read  (mem_read),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural memory driven by the DUT.
  logic [31:0] mem [0:DEPTH-1];
  logic [31:0] mem_off;
  logic [10:0] mem_idx;
  assign mem_off   = mem_addr - BASE;
  assign mem_idx   = mem_off[12:2];
  assign mem_rdata = mem[mem_idx];
  always @(posedge clk) if (mem_write) mem[mem_idx] <= mem_wdata;

  // Bench-side reference contents, updated when a transaction is issued.
  logic [31:0] ref_mem [0:DEPTH-1];

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];
  int   gnt_log[$];
  int   ack_cyc[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (mem_read)  rd_cnt++;
    if (mem_write) wr_cnt++;
  end

  // Response monitor: pops the scoreboard on each ack.
  always @(negedge clk) begin
    exp_t e;
    if (m0_ack && m1_ack) chk("ack_overlap", m1_ack, 1'b0);
    if (m0_ack) begin
      if (q0.size() == 0) chk("m0_spurious_ack", m0_ack, 1'b0);
      else begin
        e = q0.pop_front();
        chk("m0_err", m0_err, e.err);
        chk("m0_rdata", m0_rdata, e.rdata);
        gnt_log.push_back(0);
        ack_cyc.push_back(cyc);
      end
    end
    if (m1_ack) begin
      if (q1.size() == 0) chk("m1_spurious_ack", m1_ack, 1'b0);
      else begin
        e = q1.pop_front();
        chk("m1_err", m1_err, e.err);
        chk("m1_rdata", m1_rdata, e.rdata);
        gnt_log.push_back(1);
        ack_cyc.push_back(cyc);
      end
    end
  end

  // Computes the expected response from the address window and reference contents.
  task automatic push_exp(input int p, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata);
    exp_t    e;
    longint  a;
    int      idx;
    a      = longint'(addr);
    e.err  = (a % 4 != 0) || (a < longint'(BASE)) || (a >= longint'(BASE) + 4 * DEPTH);
    idx    = int'((a - longint'(BASE)) / 4);
    e.rdata = '0;
    if (!e.err) begin
      if (we) ref_mem[idx] = wdata;
      else    e.rdata = ref_mem[idx];
    end
    if (p == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic drive(input int p, input logic req, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (p == 0) begin
      m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_req = req;
    end else begin
      m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_req = req;
    end
  endtask

  // Issues one request, holds it until ack (bounded), then drops it after the ack cycle.
  task automatic xfer(input int p, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata);
    int   n;
    logic a;
    push_exp(p, we, addr, wdata);
    drive(p, 1'b1, we, addr, wdata);
    n = 0;
    a = 1'b0;
    while (!a && n < 20) begin
      @(negedge clk);
      a = (p == 0) ? m0_ack : m1_ack;
      n++;
    end
    chk(p == 0 ? "m0_ack_seen" : "m1_ack_seen", a, 1'b1);
    @(posedge clk);
    #1;
    drive(p, 1'b0, we, addr, wdata);
  endtask

  initial begin
    int rd0, wr0;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = 32'hA500_0000 | i;
      ref_mem[i] = 32'hA500_0000 | i;
    end
    mem[5]     = 32'hCAFE_F00D;
    ref_mem[5] = 32'hCAFE_F00D;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m0_ack", m0_ack, 1'b0);
    chk("rst_m1_ack", m1_ack, 1'b0);
    chk("rst_mem_read", mem_read, 1'b0);
    chk("rst_mem_write", mem_write, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Single read with cycle-accurate strobe and ack timing.
    @(posedge clk);
    #1;
    push_exp(0, 1'b0, 32'h1001_0014, 32'h0);
    drive(0, 1'b1, 1'b0, 32'h1001_0014, 32'h0);
    rd0 = rd_cnt;
    @(posedge clk);
    #1;
    chk("rd_mem_read_on", mem_read, 1'b1);
    chk("rd_mem_addr", mem_addr, 32'h1001_0014);
    chk("rd_ack_early", m0_ack, 1'b0);
    @(posedge clk);
    #1;
    chk("rd_mem_read_off", mem_read, 1'b0);
    chk("rd_ack_on", m0_ack, 1'b1);
    chk("rd_rdata_direct", m0_rdata, 32'hCAFE_F00D);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("rd_ack_off", m0_ack, 1'b0);
    chk("rd_pulse_count", rd_cnt - rd0, 32'd1);

    // Write then read back on port 1.
    wr0 = wr_cnt;
    xfer(1, 1'b1, 32'h1001_0000, 32'h1234_5678);
    chk("wr_pulse_count", wr_cnt - wr0, 32'd1);
    xfer(1, 1'b0, 32'h1001_0000, 32'h0);
    xfer(0, 1'b0, 32'h1001_1FFC, 32'h0);

    // Rejected addresses never reach the memory.
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    xfer(0, 1'b0, 32'h1001_0002, 32'h0);
    xfer(0, 1'b0, 32'h1000_FFFC, 32'h0);
    xfer(0, 1'b0, 32'h1001_2000, 32'h0);
    xfer(0, 1'b1, 32'h1001_2000, 32'hDEAD_BEEF);
    chk("err_no_read", rd_cnt - rd0, 32'd0);
    chk("err_no_write", wr_cnt - wr0, 32'd0);

    // Contention from reset: grants alternate starting with port 0.
    @(negedge clk);
    reset = 1'b0;
    gnt_log.delete();
    ack_cyc.delete();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    fork
      begin
        xfer(0, 1'b0, 32'h1001_0014, 32'h0);
        xfer(0, 1'b0, 32'h1001_0018, 32'h0);
      end
      begin
        xfer(1, 1'b0, 32'h1001_001C, 32'h0);
        xfer(1, 1'b0, 32'h1001_0020, 32'h0);
      end
    join
    chk("cont_count", gnt_log.size(), 32'd4);
    if (gnt_log.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("cont_order", gnt_log[i], i % 2);
        if (i > 0) chk("cont_spacing", ack_cyc[i] - ack_cyc[i-1], 32'd3);
      end
    end

    // Reset during the ACCESS of a port-1 write.
    @(posedge clk);
    #1;
    drive(1, 1'b1, 1'b1, 32'h1001_0100, 32'h5555_AAAA);
    @(posedge clk);
    #1;
    chk("mid_write_on", mem_write, 1'b1);
    reset = 1'b0;
    #1;
    chk("mid_write_drop", mem_write, 1'b0);
    chk("mid_addr_drop", mem_addr, 32'h0);
    chk("mid_wdata_drop", mem_wdata, 32'h0);
    chk("mid_m1_ack", m1_ack, 1'b0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    gnt_log.delete();
    @(posedge clk);
    #1;
    fork
      xfer(0, 1'b0, 32'h1001_0014, 32'h0);
      xfer(1, 1'b0, 32'h1001_0000, 32'h0);
    join
    chk("post_rst_count", gnt_log.size(), 32'd2);
    if (gnt_log.size() > 0) chk("post_rst_first", gnt_log[0], 32'd0);
    chk("q0_drained", q0.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
